// File: rtl/aes_pkg.sv
// Shared AES constants and types for the round controller and key-schedule blocks.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned AES_DW = 128;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ctrl_state_e;

  typedef logic [3:0] round_idx_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: owns the cipher state and round counter, drives an external round datapath.
// Optional abort input enabled by defining AES_CTRL_ABORT_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR,
  parameter int unsigned DW = AES_DW
) (
`ifdef AES_CTRL_ABORT_EN
  input  logic          abort,
`endif
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output round_idx_t    rk_idx,
  input  logic [DW-1:0] rk,
  output logic [DW-1:0] dp_state,
  output logic          dp_mix_en,
  input  logic [DW-1:0] dp_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  localparam round_idx_t NR_IDX = round_idx_t'(NR);

  ctrl_state_e   fsm_q, fsm_d;
  logic [DW-1:0] state_q, state_d;
  round_idx_t    rnd_q, rnd_d;
  logic          abort_w;

`ifdef AES_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = in_data ^ rk;
          rnd_d   = round_idx_t'(1);
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = dp_result;
        if (rnd_q == NR_IDX) begin
          fsm_d = DONE;
        end else begin
          rnd_d = rnd_q + round_idx_t'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
          rnd_d = '0;
        end
      end
      default: fsm_d = IDLE;
    endcase
    // Abort overrides both the round step and a concurrent output handshake.
    if (abort_w && (fsm_q != IDLE)) begin
      fsm_d   = IDLE;
      state_d = '0;
      rnd_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  // rnd is 0 whenever idle, so it doubles as the key index for the initial AddRoundKey.
  assign in_ready  = (fsm_q == IDLE) && !abort_w;
  assign rk_idx    = rnd_q;
  assign dp_state  = state_q;
  assign dp_mix_en = (fsm_q == RUN) && (rnd_q != NR_IDX);
  assign out_valid = (fsm_q == DONE);
  assign out_data  = state_q;

endmodule
